// File: rtl/mdu_unit_pkg.sv
// Shared MDU operation codes and decode helpers for the multiply/divide unit and the D-stage decoder.
package mdu_unit_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_arith_op(input logic [3:0] op);
        logic res;
        case (op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: res = 1'b1;
            default:                                res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_mult_op(input logic [3:0] op);
        logic res;
        case (op)
            MDU_MULT, MDU_MULTU: res = 1'b1;
            default:             res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply / 32-bit divide datapath; wr_en is low when the result must not be committed.
module mdu_arith
    import mdu_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        wr_en
);

    logic signed [63:0] prod_signed_s;
    logic        [63:0] prod_unsigned_s;
    logic        [31:0] sdiv_s;
    logic        [31:0] udiv_s;
    logic signed [31:0] quot_signed_s;
    logic signed [31:0] rem_signed_s;
    logic        [31:0] quot_unsigned_s;
    logic        [31:0] rem_unsigned_s;
    logic               div_zero_s;
    logic               div_ovf_s;

    assign prod_signed_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_unsigned_s = {32'd0, a} * {32'd0, b};

    // Substituting 1 for the divisor on 0x80000000/-1 yields exactly the wrapped
    // quotient 0x80000000 and remainder 0, and avoids an overflowing division.
    assign div_zero_s      = (b == 32'd0);
    assign div_ovf_s       = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign sdiv_s          = (div_zero_s || div_ovf_s) ? 32'd1 : b;
    assign udiv_s          = div_zero_s ? 32'd1 : b;
    assign quot_signed_s   = $signed(a) / $signed(sdiv_s);
    assign rem_signed_s    = $signed(a) % $signed(sdiv_s);
    assign quot_unsigned_s = a / udiv_s;
    assign rem_unsigned_s  = a % udiv_s;

    // Result select by operation
    always_comb begin
        hi    = 32'd0;
        lo    = 32'd0;
        wr_en = 1'b0;
        case (op)
            MDU_MULT: begin
                hi    = prod_signed_s[63:32];
                lo    = prod_signed_s[31:0];
                wr_en = 1'b1;
            end
            MDU_MULTU: begin
                hi    = prod_unsigned_s[63:32];
                lo    = prod_unsigned_s[31:0];
                wr_en = 1'b1;
            end
            MDU_DIV: begin
                hi    = rem_signed_s;
                lo    = quot_signed_s;
                wr_en = !div_zero_s;
            end
            MDU_DIVU: begin
                hi    = rem_unsigned_s;
                lo    = quot_unsigned_s;
                wr_en = !div_zero_s;
            end
            default: begin
                hi    = 32'd0;
                lo    = 32'd0;
                wr_en = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models multi-cycle latency with a busy counter,
// and reports MDUing to the hazard unit.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] MDU_Out,
    output logic        Busy,
    output logic        MDUing,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_state_e       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [31:0]      hi_r, hi_nxt_s;
    logic [31:0]      lo_r, lo_nxt_s;
    logic [31:0]      pend_hi_r, pend_hi_nxt_s;
    logic [31:0]      pend_lo_r, pend_lo_nxt_s;
    logic             pend_wr_r, pend_wr_nxt_s;
    logic             busy_r;
    logic [31:0]      arith_hi_s;
    logic [31:0]      arith_lo_s;
    logic             arith_wr_s;

    mdu_arith u_arith (
        .op    (MDUOp),
        .a     (A),
        .b     (B),
        .hi    (arith_hi_s),
        .lo    (arith_lo_s),
        .wr_en (arith_wr_s)
    );

    // Next-state, counter and HI/LO update logic
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        hi_nxt_s      = hi_r;
        lo_nxt_s      = lo_r;
        pend_hi_nxt_s = pend_hi_r;
        pend_lo_nxt_s = pend_lo_r;
        pend_wr_nxt_s = pend_wr_r;
        case (state_r)
            ST_IDLE: begin
                if (Start && is_arith_op(MDUOp)) begin
                    state_nxt_s   = ST_RUN;
                    cnt_nxt_s     = is_mult_op(MDUOp) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    pend_hi_nxt_s = arith_hi_s;
                    pend_lo_nxt_s = arith_lo_s;
                    pend_wr_nxt_s = arith_wr_s;
                end else if (MDUOp == MDU_MTHI) begin
                    hi_nxt_s = A;
                end else if (MDUOp == MDU_MTLO) begin
                    lo_nxt_s = A;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Start and MTHI/MTLO are deliberately not looked at while running.
                if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    if (pend_wr_r) begin
                        hi_nxt_s = pend_hi_r;
                        lo_nxt_s = pend_lo_r;
                    end else begin
                        hi_nxt_s = hi_r;
                        lo_nxt_s = lo_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter, HI/LO and pending-result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_wr_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            hi_r      <= hi_nxt_s;
            lo_r      <= lo_nxt_s;
            pend_hi_r <= pend_hi_nxt_s;
            pend_lo_r <= pend_lo_nxt_s;
            pend_wr_r <= pend_wr_nxt_s;
            busy_r    <= (state_nxt_s == ST_RUN);
        end
    end

    // mfhi/mflo read port
    always_comb begin
        MDU_Out = 32'd0;
        case (MDUOp)
            MDU_MFHI: MDU_Out = hi_r;
            MDU_MFLO: MDU_Out = lo_r;
            default:  MDU_Out = 32'd0;
        endcase
    end

    assign Busy   = busy_r;
    assign MDUing = Start | busy_r;
    assign HI     = hi_r;
    assign LO     = lo_r;

endmodule
